// File: rtl/sample_arb_if.sv
// ---------------------------------------------------------------------------
// sample_arb_if
//   Bundles the requester-facing signals of the sampling-channel scheduler.
//   master : requester side (drives req/div/din, observes grants and results)
//   slave  : scheduler side (sample_arb)
//
//   req      requester -> arb   NREQ   level request per requester
//   div      requester -> arb   DIV_W  settle cycles before capture
//   din      requester -> arb   1      signal being sampled
//   gnt      arb -> requester   NREQ   one-hot grant while waiting
//   ack      arb -> requester   NREQ   one-hot one-cycle capture-complete pulse
//   dout     arb -> requester   1      captured din value
//   dout_id  arb -> requester   ID_W   index of requester owning dout
//   busy     arb -> requester   1      scheduler not idle
// ---------------------------------------------------------------------------
interface sample_arb_if #(
    parameter int NREQ  = 4,
    parameter int DIV_W = 4,
    parameter int ID_W  = 2
);
    logic [NREQ-1:0]  req;
    logic [DIV_W-1:0] div;
    logic             din;
    logic [NREQ-1:0]  gnt;
    logic [NREQ-1:0]  ack;
    logic             dout;
    logic [ID_W-1:0]  dout_id;
    logic             busy;

    modport master (
        output req, div, din,
        input  gnt, ack, dout, dout_id, busy
    );

    modport slave (
        input  req, div, din,
        output gnt, ack, dout, dout_id, busy
    );
endinterface

// File: rtl/sample_arb.sv
// ---------------------------------------------------------------------------
// sample_arb
//   Round-robin scheduler sharing one 1-bit sampling channel among NREQ
//   requesters. The winner waits div settle cycles, then din is captured
//   and returned with a one-cycle ack. Only one capture is in flight.
//
//   clk   in   system clock, rising edge
//   rst   in   asynchronous reset, active-low
//   bus   slave modport of sample_arb_if (req/div/din in,
//         gnt/ack/dout/dout_id/busy out, all outputs registered)
// ---------------------------------------------------------------------------
module sample_arb #(
    parameter int NREQ  = 4,
    parameter int DIV_W = 4,
    parameter int ID_W  = 2
) (
    input  logic        clk,
    input  logic        rst,
    sample_arb_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t           state;
    logic [ID_W-1:0]  ptr;     // scan start for the next arbitration
    logic [ID_W-1:0]  id;      // requester currently being served
    logic [DIV_W-1:0] cnt;     // remaining settle cycles
    logic [ID_W-1:0]  winner;
    logic             found;

    function automatic logic [ID_W-1:0] next_of(input logic [ID_W-1:0] i);
        return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [ID_W-1:0] i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Wrap-around priority scan starting at ptr; first set request wins.
    always_comb begin : scan
        int idx;
        // NOTE: every combinational output gets a default before any
        // conditional assignment, otherwise a latch is inferred.
        idx    = 0;
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && bus.req[ID_W'(idx)]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge regardless of order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ptr         <= '0;
            id          <= '0;
            cnt         <= '0;
            bus.gnt     <= '0;
            bus.ack     <= '0;
            bus.dout    <= 1'b0;
            bus.dout_id <= '0;
            bus.busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        id       <= winner;
                        gnt_set(winner);
                        cnt      <= bus.div;    // div is frozen for this transaction
                        bus.busy <= 1'b1;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    // Abort takes precedence over the settle counter.
                    if (!bus.req[id]) begin
                        bus.gnt  <= '0;
                        bus.busy <= 1'b0;
                        ptr      <= next_of(id);
                        state    <= IDLE;
                    end else if (cnt == '0) begin
                        bus.dout    <= bus.din;
                        bus.dout_id <= id;
                        bus.ack     <= onehot(id);
                        bus.gnt     <= '0;
                        ptr         <= next_of(id);
                        state       <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    bus.ack  <= '0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Keeps the grant update readable inside the FSM.
    task automatic gnt_set(input logic [ID_W-1:0] i);
        bus.gnt <= onehot(i);
    endtask

endmodule

// File: tb/tb_sample_arb.sv
// ---------------------------------------------------------------------------
// tb_sample_arb
//   Directed scenarios followed by a randomized run against a transaction-
//   level reference model (timeline of grant / capture / re-arbitration
//   edges rather than a state machine).
// ---------------------------------------------------------------------------
module tb_sample_arb;

    localparam int NREQ  = 4;
    localparam int DIV_W = 4;
    localparam int ID_W  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    sample_arb_if #(.NREQ(NREQ), .DIV_W(DIV_W), .ID_W(ID_W)) bus ();

    sample_arb #(.NREQ(NREQ), .DIV_W(DIV_W), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        bus.req = '0;
        bus.div = '0;
        bus.din = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    function automatic int idx_of(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // {gnt, ack, busy, dout, dout_id}
    function automatic logic [2*NREQ+ID_W+1:0] outs();
        return {bus.gnt, bus.ack, bus.busy, bus.dout, bus.dout_id};
    endfunction

    // ---------------------------------------------------------------- reset
    task automatic test_reset();
        rst     = 1'b0;
        bus.req = 4'b1111;
        bus.div = 4'd3;
        bus.din = 1'b1;
        tick();
        n_cmp++;
        if (outs() !== '0) begin
            n_err++;
            $display("FAIL reset_hold: outs=%h required 0", outs());
        end
        tick();
        n_cmp++;
        if (outs() !== '0) begin
            n_err++;
            $display("FAIL reset_hold2: outs=%h required 0", outs());
        end
        bus.req = '0;
        rst     = 1'b1;
        tick();
        n_cmp++;
        if (outs() !== '0) begin
            n_err++;
            $display("FAIL reset_idle: outs=%h required 0", outs());
        end
    endtask

    // ------------------------------------------------------ single capture
    task automatic test_single();
        do_reset();
        bus.req = 4'b0001;
        bus.div = 4'd3;
        bus.din = 1'b1;
        tick();                              // grant edge k
        for (int i = 0; i < 4; i++) begin    // edges k .. k+3
            n_cmp++;
            if (bus.gnt !== 4'b0001 || bus.ack !== 4'b0000 || bus.busy !== 1'b1) begin
                n_err++;
                $display("FAIL single_wait[%0d]: gnt=%b ack=%b busy=%b required 0001 0000 1",
                         i, bus.gnt, bus.ack, bus.busy);
            end
            tick();
        end
        n_cmp++;                             // edge k+4: capture
        if (bus.ack !== 4'b0001 || bus.gnt !== 4'b0000 || bus.dout !== 1'b1 ||
            bus.dout_id !== 2'd0 || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_ack: ack=%b gnt=%b dout=%b id=%0d busy=%b required 0001 0000 1 0 1",
                     bus.ack, bus.gnt, bus.dout, bus.dout_id, bus.busy);
        end
        bus.req = '0;
        tick();
        n_cmp++;
        if (bus.ack !== 4'b0000 || bus.busy !== 1'b0 || bus.dout !== 1'b1) begin
            n_err++;
            $display("FAIL single_done: ack=%b busy=%b dout=%b required 0000 0 1",
                     bus.ack, bus.busy, bus.dout);
        end
    endtask

    // --------------------------------------------------------- round robin
    task automatic test_round_robin();
        int exp_ids[5] = '{0, 1, 2, 3, 0};
        int n_ack = 0;
        int last_c = 0;
        logic prev_din;
        do_reset();
        bus.req = 4'b1111;
        bus.div = 4'd0;
        for (int c = 0; c < 40 && n_ack < 5; c++) begin
            bus.din  = 1'($urandom_range(0, 1));
            prev_din = bus.din;
            tick();
            if (bus.ack !== 4'b0000) begin
                n_cmp++;
                if (idx_of(bus.ack) != exp_ids[n_ack] || bus.dout !== prev_din ||
                    int'(bus.dout_id) != exp_ids[n_ack]) begin
                    n_err++;
                    $display("FAIL rr_order[%0d]: ack=%b dout=%b id=%0d required id %0d dout %b",
                             n_ack, bus.ack, bus.dout, bus.dout_id, exp_ids[n_ack], prev_din);
                end
                if (n_ack > 0) begin
                    n_cmp++;
                    if (c - last_c != 3) begin
                        n_err++;
                        $display("FAIL rr_gap[%0d]: spacing=%0d required 3", n_ack, c - last_c);
                    end
                end
                last_c = c;
                n_ack++;
            end
        end
        n_cmp++;
        if (n_ack != 5) begin
            n_err++;
            $display("FAIL rr_count: acks=%0d required 5", n_ack);
        end
    endtask

    // --------------------------------------------------------------- abort
    task automatic test_abort();
        do_reset();
        bus.req = 4'b0001;                   // leave dout=1, ptr=1
        bus.div = 4'd0;
        bus.din = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (bus.ack !== 4'b0001 || bus.dout !== 1'b1) begin
            n_err++;
            $display("FAIL abort_setup: ack=%b dout=%b required 0001 1", bus.ack, bus.dout);
        end
        bus.req = '0;
        tick();
        bus.req = 4'b0100;
        bus.div = 4'd5;
        bus.din = 1'b0;
        for (int i = 0; i < 3; i++) begin    // WAIT cycles 1..3
            tick();
            n_cmp++;
            if (bus.gnt !== 4'b0100 || bus.ack !== 4'b0000) begin
                n_err++;
                $display("FAIL abort_wait[%0d]: gnt=%b ack=%b required 0100 0000", i, bus.gnt, bus.ack);
            end
        end
        bus.req = 4'b0000;                   // dropped during third WAIT cycle
        tick();
        n_cmp++;
        if (bus.gnt !== 4'b0000 || bus.ack !== 4'b0000 || bus.busy !== 1'b0 || bus.dout !== 1'b1) begin
            n_err++;
            $display("FAIL abort_drop: gnt=%b ack=%b busy=%b dout=%b required 0000 0000 0 1",
                     bus.gnt, bus.ack, bus.busy, bus.dout);
        end
        bus.req = 4'b1011;                   // scan from 3
        tick();
        n_cmp++;
        if (bus.gnt !== 4'b1000) begin
            n_err++;
            $display("FAIL abort_next: gnt=%b required 1000", bus.gnt);
        end
    endtask

    // ---------------------------------------------------- div change in flight
    task automatic test_div_change();
        logic exp_dout;
        do_reset();
        bus.req = 4'b0001;
        bus.div = 4'd2;
        bus.din = 1'b0;
        tick();                              // grant edge k
        bus.div  = 4'd15;
        exp_dout = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            bus.din  = ~bus.din;
            exp_dout = bus.din;
            tick();
            n_cmp++;
            if (i < 3) begin
                if (bus.ack !== 4'b0000 || bus.gnt !== 4'b0001) begin
                    n_err++;
                    $display("FAIL div_wait[%0d]: ack=%b gnt=%b required 0000 0001", i, bus.ack, bus.gnt);
                end
            end else begin
                if (bus.ack !== 4'b0001 || bus.dout !== exp_dout) begin
                    n_err++;
                    $display("FAIL div_ack: ack=%b dout=%b required 0001 %b", bus.ack, bus.dout, exp_dout);
                end
            end
        end
    endtask

    // -------------------------------------------------------- reset mid-WAIT
    task automatic test_reset_mid();
        do_reset();
        bus.req = 4'b0010;                   // complete id1 -> ptr=2
        bus.div = 4'd0;
        bus.din = 1'b1;
        tick();
        tick();
        bus.req = '0;
        tick();
        bus.req = 4'b1000;
        bus.div = 4'd7;
        tick();
        n_cmp++;
        if (bus.gnt !== 4'b1000) begin
            n_err++;
            $display("FAIL rmid_grant: gnt=%b required 1000", bus.gnt);
        end
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (outs() !== '0) begin
            n_err++;
            $display("FAIL rmid_async: outs=%h required 0", outs());
        end
        @(negedge clk);
        rst     = 1'b1;
        bus.req = 4'b1010;
        tick();
        n_cmp++;
        if (bus.gnt !== 4'b0010 || bus.busy !== 1'b1 || bus.ack !== 4'b0000) begin
            n_err++;
            $display("FAIL rmid_after: gnt=%b busy=%b ack=%b required 0010 1 0000",
                     bus.gnt, bus.busy, bus.ack);
        end
    endtask

    // ------------------------------------------------------------ random run
    // Reference model: tracks the in-flight transaction as a timeline of edge
    // numbers (capture edge, earliest next arbitration edge).
    int   m_e, m_owner, m_cap, m_next_arb, m_ptr, m_ack_edge;
    logic m_active, m_dout;
    int   m_dout_id;

    task automatic model_edge(input logic [NREQ-1:0] r, input int d, input logic di);
        m_e++;
        if (m_active) begin
            if (!r[m_owner]) begin
                m_active   = 1'b0;
                m_ptr      = (m_owner + 1) % NREQ;
                m_next_arb = m_e + 1;
            end else if (m_e == m_cap) begin
                m_dout     = di;
                m_dout_id  = m_owner;
                m_ack_edge = m_e;
                m_active   = 1'b0;
                m_ptr      = (m_owner + 1) % NREQ;
                m_next_arb = m_e + 2;
            end
        end else if (m_e >= m_next_arb && r != '0) begin
            for (int i = 0; i < NREQ; i++) begin
                if (r[(m_ptr + i) % NREQ]) begin
                    m_owner = (m_ptr + i) % NREQ;
                    break;
                end
            end
            m_active = 1'b1;
            m_cap    = m_e + d + 1;
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] r;
        logic [NREQ-1:0] exp_gnt, exp_ack, prev_gnt;
        logic            exp_busy;
        logic [2*NREQ+ID_W+1:0] exp_outs;
        int wait_cnt[NREQ];
        int d, gid;
        do_reset();
        m_e = 0; m_active = 1'b0; m_owner = 0; m_cap = 0; m_next_arb = 0;
        m_ptr = 0; m_ack_edge = -10; m_dout = 1'b0; m_dout_id = 0;
        r = '0;
        prev_gnt = '0;
        for (int j = 0; j < NREQ; j++) wait_cnt[j] = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (bus.ack[j])                                 r[j] = 1'b0;
                else if (r[j] && $urandom_range(0, 19) == 0)    r[j] = 1'b0;
                else if (!r[j] && $urandom_range(0, 3) == 0)    r[j] = 1'b1;
            end
            d       = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
            bus.req = r;
            bus.div = DIV_W'(d);
            bus.din = 1'($urandom_range(0, 1));
            model_edge(r, d, bus.din);
            tick();
            exp_gnt  = m_active ? NREQ'(1 << m_owner) : '0;
            exp_ack  = (m_ack_edge == m_e) ? NREQ'(1 << m_dout_id) : '0;
            exp_busy = m_active || (m_ack_edge == m_e);
            exp_outs = {exp_gnt, exp_ack, exp_busy, m_dout, ID_W'(m_dout_id)};
            n_cmp++;
            if (outs() !== exp_outs) begin
                n_err++;
                $display("FAIL rand_outs@%0d: {gnt,ack,busy,dout,id}=%b required %b", c, outs(), exp_outs);
            end
            n_cmp++;
            if (!$onehot0(bus.gnt) || !$onehot0(bus.ack)) begin
                n_err++;
                $display("FAIL rand_onehot@%0d: gnt=%b ack=%b required one-hot or zero", c, bus.gnt, bus.ack);
            end
            // Fairness from the DUT's own grants: a continuously waiting
            // requester sees at most NREQ-1 other grants before its own.
            for (int j = 0; j < NREQ; j++) if (!r[j]) wait_cnt[j] = 0;
            if (bus.gnt != '0 && prev_gnt == '0) begin
                gid = idx_of(bus.gnt);
                for (int j = 0; j < NREQ; j++) begin
                    if (j == gid) wait_cnt[j] = 0;
                    else if (r[j]) begin
                        wait_cnt[j]++;
                        n_cmp++;
                        if (wait_cnt[j] > NREQ - 1) begin
                            n_err++;
                            $display("FAIL rand_starve@%0d: req %0d passed over %0d times, limit %0d",
                                     c, j, wait_cnt[j], NREQ - 1);
                        end
                    end
                end
            end
            prev_gnt = bus.gnt;
        end
    endtask

    initial begin
        bus.req = '0;
        bus.div = '0;
        bus.din = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_abort();
        test_div_change();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
